// File: rtl/rv_g_wb_pkg.sv
// Shared constants and helpers for the write-back arbiter.
// Register addresses are 6 bits: 0-31 select the integer file, 32-63 the FP file.
package rv_g_wb_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int FP_BASE    = 32;

  // Data width that fits both integer and FP results.
  function automatic int ml(input int xlen, input int flen);
    return (xlen > flen) ? xlen : flen;
  endfunction

endpackage

// File: rtl/rv_g_wb_rr_arb.sv
// Round-robin arbiter, purely combinational: the search starts one past last_gnt
// and wraps, so the most recently served source has the lowest priority.
module rv_g_wb_rr_arb #(
  parameter  int NUM_SRC = 4,
  localparam int IdxW    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IdxW-1:0]    last_gnt,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IdxW-1:0]    gnt_idx,
  output logic               gnt_valid
);

  always_comb begin
    int cand;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      cand = (int'(last_gnt) + off) % NUM_SRC;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv_g_wb_arbiter.sv
// Write-back arbiter: per-source FIFOs feed a round-robin grant that loads a
// registered regfile write port (one write per cycle, never stalls).
module rv_g_wb_arbiter
  import rv_g_wb_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int FLEN       = 32,
  parameter  int NUM_SRC    = 4,
  parameter  int FIFO_DEPTH = 2,
  localparam int MaxLen     = ml(XLEN, FLEN)
) (
  input  logic                                  clk_i,
  input  logic                                  arst_ni,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]    src_addr_i,
  input  logic [NUM_SRC-1:0][MaxLen-1:0]        src_data_i,
  input  logic [NUM_SRC-1:0]                    src_valid_i,
  output logic [NUM_SRC-1:0]                    src_ready_o,
  output logic [REG_ADDR_W-1:0]                 wr_addr_o,
  output logic [MaxLen-1:0]                     wr_data_o,
  output logic                                  wr_en_o,
  output logic                                  busy_o
);

  localparam int IdxW = $clog2(NUM_SRC);
  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [MaxLen-1:0]     data;
  } wb_req_t;

  wb_req_t            head [NUM_SRC];
  logic [NUM_SRC-1:0] not_empty;
  logic [NUM_SRC-1:0] gnt;
  logic [IdxW-1:0]    gnt_idx;
  logic               gnt_valid;
  logic [IdxW-1:0]    last_gnt_q, last_gnt_d;
  wb_req_t            out_q, out_d;
  logic               wr_en_q, wr_en_d;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    wb_req_t         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    // Ready looks only at the registered count, so a full FIFO refuses a push
    // even in the cycle it is being popped.
    assign src_ready_o[gi] = (count_q != CntW'(FIFO_DEPTH));
    assign not_empty[gi]   = (count_q != '0);
    assign push            = src_valid_i[gi] && src_ready_o[gi];
    assign pop             = gnt[gi];
    assign head[gi]        = mem_q[rd_ptr_q];

    always_comb begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage needs no reset: a zero count makes stale entries unreachable.
    always_ff @(posedge clk_i) begin
      if (push) begin
        mem_q[wr_ptr_q] <= {src_addr_i[gi], src_data_i[gi]};
      end
    end
  end

  rv_g_wb_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .req       (not_empty),
    .last_gnt  (last_gnt_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    last_gnt_d = last_gnt_q;
    out_d      = out_q;
    wr_en_d    = gnt_valid;
    if (gnt_valid) begin
      last_gnt_d = gnt_idx;
      out_d      = head[gnt_idx];
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      last_gnt_q <= IdxW'(NUM_SRC - 1);
      out_q      <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      out_q      <= out_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign wr_addr_o = out_q.addr;
  assign wr_data_o = out_q.data;
  assign wr_en_o   = wr_en_q;
  assign busy_o    = (|not_empty) || wr_en_q;

endmodule
